// File: rtl/uart_tx_param_if.sv
// Payload handshake between a producer and the UART transmitter.
// Valid/DataIN come from the producer; Ready comes back from the transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 Valid;
    logic [DATA_BITS-1:0] DataIN;
    logic                 Ready;

    modport master (output Valid, output DataIN, input Ready);
    modport slave  (input Valid, input DataIN, output Ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter. A one-entry holding register feeds a
// BaudTick-paced frame FSM: start, payload, optional parity, then stop bits.
module uart_tx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           BaudTick,
    uart_tx_param_if.slave bus,
    output logic           tx,
    output logic           Busy,
    output logic           Done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_badDataBits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_badParityMode
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_badStopBits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_badMsbFirst
        $error("uart_tx_param: MSB_FIRST must be 0 or 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_holdFull;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_nextShift;
    logic                 r_parity;
    logic                 w_nextParity;
    logic [3:0]           r_bitCnt;
    logic [3:0]           w_nextBitCnt;
    logic [1:0]           r_stopCnt;
    logic [1:0]           w_nextStopCnt;
    logic                 r_tx;
    logic                 w_nextTx;
    logic                 r_done;
    logic                 w_nextDone;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_serialBit;
    logic [DATA_BITS-1:0] w_shifted;
    logic                 w_holdParity;

    assign w_accept     = bus.Valid && !r_holdFull;
    assign w_serialBit  = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
    assign w_shifted    = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
    // Parity is fixed at load time because the shift register is consumed bit by bit.
    assign w_holdParity = (^r_hold) ^ (PARITY_MODE == 2);

    assign bus.Ready = !r_holdFull;
    assign Busy      = (r_state != IDLE);
    assign tx        = r_tx;
    assign Done      = r_done;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_hold     <= '0;
            r_holdFull <= 1'b0;
        end else if (w_accept) begin
            r_hold     <= bus.DataIN;
            r_holdFull <= 1'b1;
        end else if (w_drain) begin
            r_holdFull <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bitCnt  <= 4'd0;
            r_stopCnt <= 2'd0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_shift   <= w_nextShift;
            r_parity  <= w_nextParity;
            r_bitCnt  <= w_nextBitCnt;
            r_stopCnt <= w_nextStopCnt;
            r_tx      <= w_nextTx;
            r_done    <= w_nextDone;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextShift   = r_shift;
        w_nextParity  = r_parity;
        w_nextBitCnt  = r_bitCnt;
        w_nextStopCnt = r_stopCnt;
        w_nextTx      = r_tx;
        w_nextDone    = 1'b0;
        w_drain       = 1'b0;
        if (BaudTick) begin
            case (r_state)
                IDLE: begin
                    if (r_holdFull) begin
                        w_nextTx     = 1'b0;
                        w_nextShift  = r_hold;
                        w_nextParity = w_holdParity;
                        w_drain      = 1'b1;
                        w_nextState  = START;
                    end
                end
                START: begin
                    w_nextTx     = w_serialBit;
                    w_nextShift  = w_shifted;
                    w_nextBitCnt = 4'd1;
                    w_nextState  = DATA;
                end
                DATA: begin
                    if (r_bitCnt == 4'(DATA_BITS)) begin
                        if (PARITY_MODE != 0) begin
                            w_nextTx    = r_parity;
                            w_nextState = PARITY;
                        end else begin
                            w_nextTx      = 1'b1;
                            w_nextStopCnt = 2'd1;
                            w_nextState   = STOP;
                        end
                    end else begin
                        w_nextTx     = w_serialBit;
                        w_nextShift  = w_shifted;
                        w_nextBitCnt = r_bitCnt + 4'd1;
                    end
                end
                PARITY: begin
                    w_nextTx      = 1'b1;
                    w_nextStopCnt = 2'd1;
                    w_nextState   = STOP;
                end
                STOP: begin
                    if (r_stopCnt == 2'(STOP_BITS)) begin
                        w_nextDone    = 1'b1;
                        w_nextBitCnt  = 4'd0;
                        w_nextStopCnt = 2'd0;
                        // A waiting payload starts immediately, with no idle interval.
                        if (r_holdFull) begin
                            w_nextTx     = 1'b0;
                            w_nextShift  = r_hold;
                            w_nextParity = w_holdParity;
                            w_drain      = 1'b1;
                            w_nextState  = START;
                        end else begin
                            w_nextTx    = 1'b1;
                            w_nextState = IDLE;
                        end
                    end else begin
                        w_nextStopCnt = r_stopCnt + 2'd1;
                    end
                end
                default: begin
                    w_nextTx    = 1'b1;
                    w_nextState = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, a line monitor that rebuilds
// each frame per BaudTick and compares it with frames computed from the payload.
module tb_uart_tx_param;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       BaudTick = 1'b0;
    logic       tickSeen = 1'b0;
    logic [2:0] validV = '0;
    logic [8:0] dataA [3];
    logic [2:0] readyV;
    logic [2:0] txV;
    logic [2:0] busyV;
    logic [2:0] doneV;

    logic [8:0]  sentQ [3][$];
    logic [15:0] capQ  [3][$];
    int startCnt  [3];
    int frameCnt  [3];
    int doneCnt   [3];
    int lastGap   [3];
    int expFrames [3];
    int testsRun  = 0;
    int failCount = 0;

    uart_tx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_param_if #(.DATA_BITS(7)) bus1 ();
    uart_tx_param_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.Valid  = validV[0];
    assign bus0.DataIN = dataA[0][7:0];
    assign readyV[0]   = bus0.Ready;
    assign bus1.Valid  = validV[1];
    assign bus1.DataIN = dataA[1][6:0];
    assign readyV[1]   = bus1.Ready;
    assign bus2.Valid  = validV[2];
    assign bus2.DataIN = dataA[2][7:0];
    assign readyV[2]   = bus2.Ready;

    uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) u0 (
        .CLK(CLK), .Reset(Reset), .BaudTick(BaudTick), .bus(bus0.slave),
        .tx(txV[0]), .Busy(busyV[0]), .Done(doneV[0]));
    uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(0)) u1 (
        .CLK(CLK), .Reset(Reset), .BaudTick(BaudTick), .bus(bus1.slave),
        .tx(txV[1]), .Busy(busyV[1]), .Done(doneV[1]));
    uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) u2 (
        .CLK(CLK), .Reset(Reset), .BaudTick(BaudTick), .bus(bus2.slave),
        .tx(txV[2]), .Busy(busyV[2]), .Done(doneV[2]));

    initial forever #5 CLK = ~CLK;

    initial begin
        forever begin
            repeat (15) @(negedge CLK);
            BaudTick = 1'b1;
            @(negedge CLK);
            BaudTick = 1'b0;
        end
    end

    always @(posedge CLK) tickSeen <= BaudTick;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Line image of a whole frame, bit i = interval i.
    function automatic logic [15:0] frameBits(input logic [8:0] d, input int db, input int pm,
                                              input int sb, input int mf);
        logic [15:0] f;
        logic        p;
        f = '0;
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1+i] = (mf != 0) ? d[db-1-i] : d[i];
            p      = p ^ d[i];
        end
        if (pm != 0) f[1+db] = p ^ (pm == 2);
        for (int s = 0; s < sb; s++) f[1+db+((pm != 0) ? 1 : 0)+s] = 1'b1;
        return f;
    endfunction

    task automatic monitor(input int g, input int db, input int pm, input int sb, input int mf);
        int          flen;
        int          idx;
        int          gap;
        logic        inFrame;
        logic        justEnded;
        logic [15:0] cur;
        logic [15:0] expF;
        flen      = 1 + db + ((pm != 0) ? 1 : 0) + sb;
        inFrame   = 1'b0;
        justEnded = 1'b0;
        idx       = 0;
        gap       = 0;
        cur       = '0;
        expF      = '0;
        forever begin
            @(negedge CLK);
            if (Reset !== 1'b1) begin
                inFrame   = 1'b0;
                justEnded = 1'b0;
                idx       = 0;
                gap       = 0;
                continue;
            end
            if (doneV[g]) doneCnt[g]++;
            if (!tickSeen) continue;
            checkOutput($sformatf("done_pulse%0d", g), {31'd0, doneV[g]}, {31'd0, justEnded});
            justEnded = 1'b0;
            if (!inFrame) begin
                if (txV[g] == 1'b0 && sentQ[g].size() != 0) begin
                    expF        = frameBits(sentQ[g].pop_front(), db, pm, sb, mf);
                    inFrame     = 1'b1;
                    idx         = 0;
                    cur         = '0;
                    lastGap[g]  = gap;
                    startCnt[g]++;
                end else begin
                    checkOutput($sformatf("idle_line%0d", g), {31'd0, txV[g]}, 32'd1);
                    gap++;
                end
            end
            if (inFrame) begin
                cur[idx] = txV[g];
                idx++;
                checkOutput($sformatf("busy_frame%0d", g), {31'd0, busyV[g]}, 32'd1);
                if (idx == flen) begin
                    checkOutput($sformatf("frame%0d", g), {16'd0, cur}, {16'd0, expF});
                    capQ[g].push_back(cur);
                    frameCnt[g]++;
                    inFrame   = 1'b0;
                    justEnded = 1'b1;
                    gap       = 0;
                end
            end else begin
                checkOutput($sformatf("busy_idle%0d", g), {31'd0, busyV[g]}, 32'd0);
            end
        end
    endtask

    initial begin
        fork
            monitor(0, 8, 0, 1, 0);
            monitor(1, 7, 2, 2, 0);
            monitor(2, 8, 1, 1, 1);
        join
    end

    task automatic applyStimulus(input int g, input logic [8:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        validV[g] = 1'b1;
        dataA[g]  = d;
        while (readyV[g] !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            checkOutput($sformatf("accept_timeout%0d", g), {31'd0, readyV[g]}, 32'd1);
            validV[g] = 1'b0;
            return;
        end
        sentQ[g].push_back(d);
        expFrames[g]++;
        @(negedge CLK);
        validV[g] = 1'b0;
        dataA[g]  = 9'($urandom);
        checkOutput($sformatf("ready_after_accept%0d", g), {31'd0, readyV[g]}, 32'd0);
    endtask

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(negedge CLK);
            while (!tickSeen) @(negedge CLK);
        end
        #1;
    endtask

    task automatic waitStart(input int g, input int target);
        int n;
        n = 0;
        while (startCnt[g] < target && n < 3000) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 3000) checkOutput($sformatf("start_timeout%0d", g), startCnt[g], target);
    endtask

    task automatic waitFrames(input int g, input int target);
        int n;
        n = 0;
        while (frameCnt[g] < target && n < 5000) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 5000) checkOutput($sformatf("frame_timeout%0d", g), frameCnt[g], target);
    endtask

    task automatic randomBurst(input int g);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge CLK);
            applyStimulus(g, 9'($urandom));
        end
    endtask

    initial begin
        int         base;
        int         viol;
        int         n;
        int         f0;
        int         d0;
        int         k;
        logic [8:0] entries [3];

        for (int g = 0; g < 3; g++) begin
            dataA[g]     = '0;
            startCnt[g]  = 0;
            frameCnt[g]  = 0;
            doneCnt[g]   = 0;
            lastGap[g]   = 0;
            expFrames[g] = 0;
        end
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset_tx%0d", g), {31'd0, txV[g]}, 32'd1);
            checkOutput($sformatf("reset_ready%0d", g), {31'd0, readyV[g]}, 32'd1);
            checkOutput($sformatf("reset_busy%0d", g), {31'd0, busyV[g]}, 32'd0);
            checkOutput($sformatf("reset_done%0d", g), {31'd0, doneV[g]}, 32'd0);
        end
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        $display("[TB] reset released");

        // Reference frames for each configuration.
        applyStimulus(0, 9'h0A5);
        applyStimulus(1, 9'h053);
        applyStimulus(2, 9'h081);
        waitFrames(0, 1);
        waitFrames(1, 1);
        waitFrames(2, 1);
        checkOutput("a5_default", {16'd0, capQ[0].pop_front()}, 32'h34A);
        checkOutput("53_odd_7bit_2stop", {16'd0, capQ[1].pop_front()}, 32'h7A6);
        checkOutput("81_msb_even", {16'd0, capQ[2].pop_front()}, 32'h502);

        // Back-to-back frames plus an ignored request while the register is full.
        applyStimulus(0, 9'h000);
        waitStart(0, startCnt[0] + 1);
        applyStimulus(0, 9'h0FF);
        base = startCnt[0];
        viol = 0;
        n    = 0;
        validV[0] = 1'b1;
        dataA[0]  = 9'h155;
        while (startCnt[0] == base && n < 1000) begin
            if (n == 20) validV[0] = 1'b0;
            @(negedge CLK);
            #1;
            n++;
            if (startCnt[0] == base && readyV[0]) viol++;
        end
        validV[0] = 1'b0;
        checkOutput("b2b_second_started", startCnt[0] - base, 1);
        checkOutput("b2b_ready_low", viol, 0);
        checkOutput("b2b_ready_freed", {31'd0, readyV[0]}, 32'd1);
        checkOutput("b2b_gap", lastGap[0], 0);
        waitFrames(0, frameCnt[0] + 1);
        checkOutput("b2b_first_00", {16'd0, capQ[0].pop_front()}, 32'h200);
        checkOutput("b2b_second_ff", {16'd0, capQ[0].pop_front()}, 32'h3FE);

        // Reset during bit 3 with a second payload held.
        waitTicks(2);
        applyStimulus(0, 9'h000);
        waitStart(0, startCnt[0] + 1);
        applyStimulus(0, 9'h03C);
        waitTicks(4);
        repeat (3) @(negedge CLK);
        checkOutput("pre_reset_tx_low", {31'd0, txV[0]}, 32'd0);
        #2 Reset = 1'b0;
        #1;
        checkOutput("midframe_reset_tx", {31'd0, txV[0]}, 32'd1);
        checkOutput("midframe_reset_ready", {31'd0, readyV[0]}, 32'd1);
        checkOutput("midframe_reset_busy", {31'd0, busyV[0]}, 32'd0);
        sentQ[0].delete();
        capQ[0].delete();
        expFrames[0] = expFrames[0] - 2;
        repeat (4) @(negedge CLK);
        Reset = 1'b1;
        base = startCnt[0];
        waitTicks(5);
        checkOutput("no_frame_after_reset", startCnt[0] - base, 0);
        checkOutput("tx_idle_after_reset", {31'd0, txV[0]}, 32'd1);

        // Valid held high while a three-entry source drains.
        entries[0] = 9'h03C;
        entries[1] = 9'h0C3;
        entries[2] = 9'h011;
        f0 = frameCnt[0];
        d0 = doneCnt[0];
        k  = 0;
        n  = 0;
        @(negedge CLK);
        validV[0] = 1'b1;
        dataA[0]  = entries[0];
        while (k < 3 && n < 3000) begin
            if (readyV[0]) begin
                sentQ[0].push_back(entries[k]);
                expFrames[0]++;
                k++;
            end
            @(negedge CLK);
            n++;
            if (k < 3) dataA[0] = entries[k];
        end
        validV[0] = 1'b0;
        checkOutput("queue_accepted", k, 3);
        waitFrames(0, f0 + 3);
        waitTicks(2);
        checkOutput("queue_frames", frameCnt[0] - f0, 3);
        checkOutput("queue_dones", doneCnt[0] - d0, 3);
        capQ[0].delete();

        // Randomised traffic on all three configurations at once.
        fork
            randomBurst(0);
            randomBurst(1);
            randomBurst(2);
        join
        for (int g = 0; g < 3; g++) waitFrames(g, expFrames[g]);
        waitTicks(2);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("total_frames%0d", g), frameCnt[g], expFrames[g]);
            checkOutput($sformatf("total_dones%0d", g), doneCnt[g], frameCnt[g]);
            checkOutput($sformatf("pending_payloads%0d", g), sentQ[g].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
